mul_div_unit: RTL and testbench

//  Iterative RV32M multiply/divide unit; consumes register_file RD1/RD2 beside the ALU.

---
 rtl/mul_div_unit.sv | 152 +++++++++++++++
 tb/tb_mul_div_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit with a fixed 33-edge latency.
// Shift-add multiply and restoring divide share one 64-bit accumulator.
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      rd_in,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t            state;
    logic [4:0]        count;
    logic [2:0]        op;
    logic              sa;
    logic              sb;
    logic [XLEN-1:0]   ma;
    logic [XLEN-1:0]   mb;
    logic [2*XLEN-1:0] acc;

    logic              cap_sa;
    logic              cap_sb;
    logic [XLEN-1:0]   cap_ma;
    logic [XLEN-1:0]   cap_mb;

    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_sh;
    logic              div_ge;
    logic [XLEN-1:0]   div_diff;
    logic [2*XLEN-1:0] step_next;

    logic [2*XLEN-1:0] mul_p;
    logic [XLEN-1:0]   quo;
    logic [XLEN-1:0]   rem;
    logic [XLEN-1:0]   fix_val;

    // Operand capture: sign flags only for the signed operand positions.
    always_comb begin
        cap_sa = a[XLEN-1] & (funct3 == 3'd1 || funct3 == 3'd2 ||
                              funct3 == 3'd4 || funct3 == 3'd6);
        cap_sb = b[XLEN-1] & (funct3 == 3'd1 || funct3 == 3'd4 ||
                              funct3 == 3'd6);
        cap_ma = cap_sa ? -a : a;
        cap_mb = cap_sb ? -b : b;
    end

    // One multiply or divide iteration. Magnitudes are unsigned, so 2^31
    // fits; the 33-bit shifted remainder avoids overflow in the compare.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} +
                   (acc[0] ? {1'b0, ma} : {(XLEN+1){1'b0}});
        div_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        div_ge   = (div_sh >= {1'b0, mb});
        div_diff = div_sh[XLEN-1:0] - mb;
        if (!op[2]) begin
            step_next = {mul_sum, acc[XLEN-1:1]};
        end else if (div_ge) begin
            step_next = {div_diff, acc[XLEN-2:0], 1'b1};
        end else begin
            step_next = {div_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end
    end

    // Sign correction and divide special cases applied in FIX.
    always_comb begin
        mul_p   = (sa ^ sb) ? -acc : acc;
        quo     = (sa ^ sb) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem     = sa ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        fix_val = '0;
        case (op)
            3'd0:       fix_val = mul_p[XLEN-1:0];
            3'd1, 3'd2,
            3'd3:       fix_val = mul_p[2*XLEN-1:XLEN];
            3'd4, 3'd5: fix_val = (mb == '0) ? '1 : quo;
            default:    fix_val = (mb == '0) ? (sa ? -ma : ma) : rem;
        endcase
    end

    // Control FSM with registered outputs and datapath state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            count  <= '0;
            op     <= '0;
            sa     <= 1'b0;
            sb     <= 1'b0;
            ma     <= '0;
            mb     <= '0;
            acc    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            rd_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state  <= CALC;
                        busy   <= 1'b1;
                        count  <= '0;
                        op     <= funct3;
                        rd_out <= rd_in;
                        sa     <= cap_sa;
                        sb     <= cap_sb;
                        ma     <= cap_ma;
                        mb     <= cap_mb;
                        acc    <= {{XLEN{1'b0}},
                                   funct3[2] ? cap_ma : cap_mb};
                    end
                end
                CALC: begin
                    acc   <= step_next;
                    count <= count + 5'd1;
                    if (count == 5'd31) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    result <= fix_val;
                    done   <= 1'b1;
                    state  <= DONE;
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and random checks of mul_div_unit against an arithmetic model.
// Verifies latency, done pulse, rd capture, special cases and reset abort.
module tb_mul_div_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  funct3;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd_in;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int n_assert;
    int n_fail;
    logic [31:0] last;

    mul_div_unit #(.XLEN(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .funct3 (funct3),
        .a      (a),
        .b      (b),
        .rd_in  (rd_in),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f,
                                          input logic [31:0] x,
                                          input logic [31:0] y);
        longint sx;
        longint sy;
        longint uy;
        logic [63:0] ux64;
        logic [63:0] uy64;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        uy = longint'({32'b0, y});
        ux64 = {32'b0, x};
        uy64 = {32'b0, y};
        p = '0;
        case (f)
            3'd0: begin p = sx * sy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin p = ux64 * uy64; return p[63:32]; end
            3'd4: begin
                if (y == 32'd0) return 32'hFFFFFFFF;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF)
                    return 32'h80000000;
                p = sx / sy;
                return p[31:0];
            end
            3'd5: begin
                if (y == 32'd0) return 32'hFFFFFFFF;
                return x / y;
            end
            3'd6: begin
                if (y == 32'd0) return x;
                if (x == 32'h80000000 && y == 32'hFFFFFFFF)
                    return 32'd0;
                p = sx % sy;
                return p[31:0];
            end
            default: begin
                if (y == 32'd0) return x;
                return x % y;
            end
        endcase
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'h80000000;
            2:       return 32'hFFFFFFFF;
            3:       return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    task automatic run_op(input logic [2:0] f, input logic [31:0] x,
                          input logic [31:0] y, input logic [4:0] r,
                          input bit inject, output logic [31:0] res);
        logic [31:0] exp;
        exp = model(f, x, y);
        @(negedge clk);
        funct3 = f;
        a      = x;
        b      = y;
        rd_in  = r;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        a      = $urandom;
        b      = $urandom;
        funct3 = 3'($urandom);
        rd_in  = 5'($urandom);
        for (int i = 1; i <= 33; i++) begin
            @(posedge clk);
            #1;
            if (i == 1) check("busy_calc", {31'b0, busy}, 32'd1);
            if (inject && i == 4) begin
                start  = 1'b1;
                a      = $urandom;
                b      = $urandom;
                funct3 = 3'($urandom);
            end
            if (inject && i == 5) start = 1'b0;
            check("done_timing", {31'b0, done}, {31'b0, i == 33});
        end
        check("result", result, exp);
        check("rd_out", {27'b0, rd_out}, {27'b0, r});
        res = result;
        @(posedge clk);
        #1;
        check("idle_busy", {31'b0, busy}, 32'd0);
        check("idle_done", {31'b0, done}, 32'd0);
    endtask

    initial begin
        int ndone;
        n_assert = 0;
        n_fail   = 0;
        rst    = 1'b1;
        start  = 1'b0;
        funct3 = '0;
        a      = '0;
        b      = '0;
        rd_in  = '0;
        #1;
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_rd", {27'b0, rd_out}, 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd9, 1'b0, last);
        check("mul_7x-3", last, 32'hFFFFFFEB);
        run_op(3'd1, 32'h80000000, 32'h80000000, 5'd1, 1'b0, last);
        check("mulh_min", last, 32'h40000000);
        run_op(3'd2, 32'h80000000, 32'h80000000, 5'd2, 1'b0, last);
        check("mulhsu_min", last, 32'hC0000000);
        run_op(3'd3, 32'h80000000, 32'h80000000, 5'd3, 1'b0, last);
        check("mulhu_min", last, 32'h40000000);
        run_op(3'd4, 32'hFFFFFFEC, 32'd6, 5'd4, 1'b0, last);
        check("div_-20_6", last, 32'hFFFFFFFD);
        run_op(3'd6, 32'hFFFFFFEC, 32'd6, 5'd5, 1'b0, last);
        check("rem_-20_6", last, 32'hFFFFFFFE);
        run_op(3'd5, 32'd5, 32'd0, 5'd6, 1'b0, last);
        check("divu_by0", last, 32'hFFFFFFFF);
        run_op(3'd6, 32'd5, 32'd0, 5'd7, 1'b0, last);
        check("rem_by0", last, 32'd5);
        run_op(3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd8, 1'b0, last);
        check("div_ovf", last, 32'h80000000);
        run_op(3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd10, 1'b0, last);
        check("rem_ovf", last, 32'd0);

        run_op(3'd1, 32'h12345678, 32'h9ABCDEF0, 5'd11, 1'b1, last);
        check("inject_ignored", last,
              model(3'd1, 32'h12345678, 32'h9ABCDEF0));

        for (int k = 0; k < 40; k++) begin
            run_op(3'($urandom), pick(), pick(), 5'($urandom), 1'b0, last);
        end

        run_op(3'd7, 32'd100, 32'd7, 5'd12, 1'b0, last);
        @(negedge clk);
        funct3 = 3'd4;
        a      = 32'd1000;
        b      = 32'd7;
        rd_in  = 5'd13;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_done", {31'b0, done}, 32'd0);
        check("abort_result", result, 32'd0);
        check("abort_rd", {27'b0, rd_out}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) ndone++;
        end
        check("abort_no_done", ndone, 32'd0);
        run_op(3'd3, 32'd3, 32'd5, 5'd14, 1'b0, last);
        check("mulhu_3x5", last, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
